// File: rtl/orion_types.sv
// Shared Orion core definitions used across pipeline stage boundaries.
package orion_types;

    localparam int PIPE_BUF_DEPTH_DEFAULT = 2;

endpackage

// File: rtl/orion_wrap_ctr.sv
// Modulo-MAX counter: wraps from MAX-1 back to 0 without power-of-2 masking.
module orion_wrap_ctr #(
    parameter int MAX = 2,
    parameter int W   = (MAX > 1) ? $clog2(MAX) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] val
);

    localparam logic [W-1:0] LAST = W'(MAX - 1);

    // clr wins over inc so a flush always lands the pointer at entry 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val <= '0;
        end else if (clr) begin
            val <= '0;
        end else if (inc) begin
            val <= (val == LAST) ? '0 : val + 1'b1;
        end
    end

endmodule

// File: rtl/orion_pipe_buf.sv
// Elastic valid/ready FIFO between Orion core stages, with synchronous flush.
module orion_pipe_buf
    import orion_types::*;
#(
    parameter int DATAW_P   = 32,
    parameter int DEPTH     = PIPE_BUF_DEPTH_DEFAULT,
    parameter int AFULL_LVL = DEPTH - 1,
    parameter int CNTW      = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [DATAW_P-1:0] in_data_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [DATAW_P-1:0] out_data_o,
    output logic [CNTW-1:0]    count_o,
    output logic               afull_o
);

    localparam int              PTRW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNTW-1:0] FULL_CNT  = CNTW'(DEPTH);
    localparam logic [CNTW-1:0] AFULL_CNT = CNTW'(AFULL_LVL);

    logic [DATAW_P-1:0] mem [DEPTH];
    logic [CNTW-1:0]    count;
    logic [PTRW-1:0]    rd_ptr;
    logic [PTRW-1:0]    wr_ptr;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;

    // Ready looks only at the registered count, so a full buffer refuses
    // input even in a cycle where it is also popping.
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign push  = in_valid_i && !full && !flush_i;
    assign pop   = !empty && out_ready_i && !flush_i;

    orion_wrap_ctr #(.MAX(DEPTH), .W(PTRW)) u_wr_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush_i),
        .inc   (push),
        .val   (wr_ptr)
    );

    orion_wrap_ctr #(.MAX(DEPTH), .W(PTRW)) u_rd_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush_i),
        .inc   (pop),
        .val   (rd_ptr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (flush_i) begin
            count <= '0;
        end else if (push && !pop) begin
            count <= count + 1'b1;
        end else if (pop && !push) begin
            count <= count - 1'b1;
        end
    end

    // Storage is deliberately unreset; empty masking hides stale entries.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data_i;
        end
    end

    assign in_ready_o  = !full;
    assign out_valid_o = !empty;
    assign out_data_o  = empty ? '0 : mem[rd_ptr];
    assign count_o     = count;
    assign afull_o     = (count >= AFULL_CNT);

endmodule

// File: tb/tb_orion_pipe_buf.sv
// Bench for orion_pipe_buf: three configurations share stimulus, checked against a list model.
module tb_orion_pipe_buf;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;

    logic       o_valid [3];
    logic [7:0] o_data  [3];
    logic       i_ready [3];
    logic       a_full  [3];
    logic [31:0] o_cnt  [3];
    logic [1:0] c0;
    logic [1:0] c1;
    logic [0:0] c2;

    int checks;
    int failures;

    // Reference model: ordered list per instance, oldest entry at index 0
    int         mdep [3] = '{2, 3, 1};
    int         mafl [3] = '{1, 2, 1};
    int         mcnt [3];
    logic [7:0] mlist [3][17];

    typedef struct {
        logic       flush;
        logic       vin;
        logic [7:0] d;
        logic       ordy;
        logic       ev;
        logic [7:0] ed;
        int         ec;
        logic       erdy;
        logic       eaf;
    } vec_t;
    vec_t tbl [15];

    orion_pipe_buf #(.DATAW_P(8), .DEPTH(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(i_ready[0]), .in_data_i(in_data), .out_valid_o(o_valid[0]),
        .out_ready_i(out_ready), .out_data_o(o_data[0]), .count_o(c0), .afull_o(a_full[0])
    );

    orion_pipe_buf #(.DATAW_P(8), .DEPTH(3), .AFULL_LVL(2)) u_d3 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(i_ready[1]), .in_data_i(in_data), .out_valid_o(o_valid[1]),
        .out_ready_i(out_ready), .out_data_o(o_data[1]), .count_o(c1), .afull_o(a_full[1])
    );

    orion_pipe_buf #(.DATAW_P(8), .DEPTH(1), .AFULL_LVL(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(i_ready[2]), .in_data_i(in_data), .out_valid_o(o_valid[2]),
        .out_ready_i(out_ready), .out_data_o(o_data[2]), .count_o(c2), .afull_o(a_full[2])
    );

    assign o_cnt[0] = {30'd0, c0};
    assign o_cnt[1] = {30'd0, c1};
    assign o_cnt[2] = {31'd0, c2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [7:0] ed;
        for (int k = 0; k < 3; k++) begin
            ed = (mcnt[k] > 0) ? mlist[k][0] : 8'h00;
            chk($sformatf("valid%0d", k), 32'(o_valid[k]), 32'(mcnt[k] > 0));
            chk($sformatf("data%0d", k),  32'(o_data[k]),  32'(ed));
            chk($sformatf("count%0d", k), o_cnt[k],        32'(mcnt[k]));
            chk($sformatf("ready%0d", k), 32'(i_ready[k]), 32'(mcnt[k] < mdep[k]));
            chk($sformatf("afull%0d", k), 32'(a_full[k]),  32'(mcnt[k] >= mafl[k]));
        end
    endtask

    // Apply this cycle's handshake rules to the model, using pre-edge state
    task automatic model_step();
        logic acc;
        logic take;
        for (int k = 0; k < 3; k++) begin
            if (!rst_n || flush) begin
                mcnt[k] = 0;
            end else begin
                acc  = in_valid && (mcnt[k] < mdep[k]);
                take = (mcnt[k] > 0) && out_ready;
                if (take) begin
                    for (int i = 0; i < 16; i++) mlist[k][i] = mlist[k][i+1];
                    mcnt[k] = mcnt[k] - 1;
                end
                if (acc) begin
                    mlist[k][mcnt[k]] = in_data;
                    mcnt[k] = mcnt[k] + 1;
                end
            end
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        int n;
        checks    = 0;
        failures  = 0;
        mcnt      = '{0, 0, 0};
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;

        tbl[0]  = '{1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 8'h11, 1, 1'b1, 1'b1};
        tbl[1]  = '{1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 8'h22, 1, 1'b1, 1'b1};
        tbl[2]  = '{1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 8'h33, 1, 1'b1, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 8'h44, 1'b0, 1'b1, 8'h44, 1, 1'b1, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 8'h44, 2, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 8'h66, 1'b0, 1'b1, 8'h44, 2, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 8'h77, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 8'h88, 1'b0, 1'b1, 8'h88, 1, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 8'h99, 1'b0, 1'b1, 8'h99, 1, 1'b1, 1'b1};
        tbl[12] = '{1'b0, 1'b1, 8'haa, 1'b0, 1'b1, 8'h99, 2, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 1'b1, 8'hbb, 1'b1, 1'b1, 8'haa, 1, 1'b1, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b0};

        // Reset then idle
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("rst_ready", 32'(i_ready[0]), 32'd1);
        chk("rst_valid", 32'(o_valid[0]), 32'd0);
        chk("rst_data",  32'(o_data[0]),  32'd0);
        chk("rst_count", o_cnt[0],        32'd0);
        #2 rst_n = 1'b1;

        // DEPTH=2 streaming, fill, full-refuse, flush-with-push vectors
        for (int i = 0; i < 15; i++) begin
            flush     = tbl[i].flush;
            in_valid  = tbl[i].vin;
            in_data   = tbl[i].d;
            out_ready = tbl[i].ordy;
            cyc();
            chk($sformatf("tbl%0d_valid", i), 32'(o_valid[0]), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_data", i),  32'(o_data[0]),  32'(tbl[i].ed));
            chk($sformatf("tbl%0d_count", i), o_cnt[0],        32'(tbl[i].ec));
            chk($sformatf("tbl%0d_ready", i), 32'(i_ready[0]), 32'(tbl[i].erdy));
            chk($sformatf("tbl%0d_afull", i), 32'(a_full[0]),  32'(tbl[i].eaf));
        end

        // DEPTH=3 fill and stall, then drain
        flush = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        cyc();
        flush = 1'b0; in_valid = 1'b1;
        in_data = 8'ha1; cyc();
        chk("fs_afull_a", 32'(a_full[1]), 32'd0);
        in_data = 8'hb2; cyc();
        chk("fs_afull_b", 32'(a_full[1]), 32'd1);
        chk("fs_ready_b", 32'(i_ready[1]), 32'd1);
        in_data = 8'hc3; cyc();
        chk("fs_ready_c", 32'(i_ready[1]), 32'd0);
        chk("fs_count_c", o_cnt[1], 32'd3);
        in_data = 8'hd4; cyc();
        chk("fs_count_d", o_cnt[1], 32'd3);
        chk("fs_head_d",  32'(o_data[1]), 32'h0a1);
        in_valid = 1'b0; out_ready = 1'b1;
        cyc(); chk("fs_drain_b", 32'(o_data[1]), 32'h0b2);
        cyc(); chk("fs_drain_c", 32'(o_data[1]), 32'h0c3);
        cyc(); chk("fs_drain_empty", 32'(o_valid[1]), 32'd0);

        // DEPTH=3 pointer wrap with out_ready toggling
        for (int i = 0; i < 20; i++) begin
            in_valid  = 1'b1;
            in_data   = 8'(8'h20 + i);
            out_ready = 1'(i % 2);
            cyc();
            chk("wrap_cnt_le3", 32'(o_cnt[1] <= 32'd3), 32'd1);
        end

        // Randomized traffic, occasional flush
        for (int i = 0; i < 400; i++) begin
            flush     = ($urandom_range(15) == 0);
            in_valid  = 1'($urandom_range(1));
            in_data   = 8'($urandom);
            out_ready = 1'($urandom_range(1));
            cyc();
        end

        // DEPTH=1 throughput: one transfer every two cycles
        flush = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        cyc();
        flush = 1'b0; in_valid = 1'b1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            in_data = 8'(8'h60 + i);
            cyc();
            if (o_valid[2]) n++;
        end
        chk("d1_thru", 32'(n), 32'd4);
        in_data = 8'h70;
        cyc();
        chk("d1_mid_valid", 32'(o_valid[2]), 32'd1);

        // Asynchronous reset mid-stream clears outputs without a clock edge
        #2 rst_n = 1'b0;
        #1;
        mcnt = '{0, 0, 0};
        check_all();
        chk("arst_valid", 32'(o_valid[2]), 32'd0);
        chk("arst_data",  32'(o_data[2]),  32'd0);
        chk("arst_ready", 32'(i_ready[2]), 32'd1);
        in_valid = 1'b0;
        cyc();
        rst_n = 1'b1;
        in_valid = 1'b1; in_data = 8'h5a; out_ready = 1'b0;
        cyc();
        chk("post_rst_data", 32'(o_data[0]), 32'h05a);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/orion_pipe_buf.md
# orion_pipe_buf

Parametrised elastic pipeline buffer placed between Orion core stages. Examples are IF→ID (carrying `if_id_t`) and ID→EX (carrying `id_ex_t`). It replaces the fixed single-register stage boundary with a DEPTH-entry valid/ready FIFO that has a synchronous flush. This lets stalls and branch-redirect kills apply per stage without combinational ready chains. Payload is an opaque packed vector; callers cast the stage struct in and out.

## Interface
Parameters:
- `DATAW_P`, default 32: payload width in bits; instantiated as `$bits(<stage struct>)`.
- `DEPTH`, default 2: number of entries; legal range 1–16; need not be a power of 2.
- `AFULL_LVL`, default `DEPTH-1`: occupancy at or above which `afull_o` is asserted; legal range 1–DEPTH.
- `CNTW`, default `$clog2(DEPTH+1)`: width of the occupancy count; derived, do not override.

Ports:
- `clk` input 1: clock. One clock; all state on rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `flush_i` input 1: synchronous flush; kills every stored entry and any push in the same cycle.
- `in_valid_i` input 1: upstream has data.
- `in_ready_o` output 1: buffer can accept data; equals `!full`.
- `in_data_i` input DATAW_P: upstream payload.
- `out_valid_o` output 1: buffer holds data; equals `!empty`.
- `out_ready_i` input 1: downstream accepts data.
- `out_data_o` output DATAW_P: oldest entry; forced to 0 when empty.
- `count_o` output CNTW: current occupancy, 0..DEPTH.
- `afull_o` output 1: high when `count_o >= AFULL_LVL`.

## Operation
- Push: occurs when `in_valid_i && in_ready_o && !flush_i`. Writes `mem[wr_ptr]` and advances `wr_ptr`.
- Pop: occurs when `out_valid_o && out_ready_i && !flush_i`. Advances `rd_ptr`.
- Both pointers wrap from DEPTH-1 to 0 explicitly; no power-of-2 masking.
- Count update: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
- `in_ready_o` depends only on registered count. There is no path from `out_ready_i` to `in_ready_o`. A full buffer refuses input even while it is popping that cycle.
- Consequence: DEPTH=1 sustains half throughput. DEPTH≥2 sustains one transfer per cycle.
- Flush:
  - Next state is `count=0` and `rd_ptr=wr_ptr=0`.
  - Storage contents are left as is.
  - Flush has priority over push and pop in the same cycle.
  - Handshake signals still show the pre-flush state during the flush cycle, but no transfer is counted on either side.
- Empty: `out_valid_o=0` and `out_data_o=0`. The payload `valid` field therefore reads 0 downstream.
- Full: `in_ready_o=0`. A push attempt is ignored and causes no overwrite.
- Protocol requirement on the producer: once `in_valid_i` rises, data stays stable until accepted, unless `flush_i` intervenes.

## Timing
- Latency: data pushed in cycle N appears on `out_data_o` with `out_valid_o=1` in cycle N+1. There is no same-cycle bypass.
- All outputs are derived from registers. At most a read mux sits on `out_data_o`; there is no combinational input→output path.
- Reset (asynchronous assert, synchronous release) gives:
  - `in_ready_o=1`, `out_valid_o=0`, `out_data_o=0`, `count_o=0`.
  - `afull_o=0`; AFULL_LVL≥1 guarantees this.
  - Pointers at 0.
- Storage array has no reset.
- Reset mid-transfer: all entries are lost and no pop completes. Upstream must re-present its data.
- Flush in cycle N: `out_valid_o=0` and `count_o=0` from cycle N+1.
- A push in cycle N+1 appears at the output in N+2.

## Structure
- No new package types are required. Instantiations use existing stage structs, e.g. `if_id_t` and `id_ex_t`, sized by `$bits`.
- Add `PIPE_BUF_DEPTH_DEFAULT = 2` to `orion_types` as the shared default.
- One sub-module: `orion_wrap_ctr`, parametrised MAX. It is a modulo-MAX counter with `inc` and `clr` inputs, instantiated once for `rd_ptr` and once for `wr_ptr`.
- Count is kept as a separate register, not derived from the pointers.

## Test plan
- Reset then idle, DEPTH=2: check `in_ready_o=1`, `out_valid_o=0`, `out_data_o=0`, `count_o=0`.
- Streaming, DEPTH=2, `out_ready_i=1` constant: push 0x11, 0x22, 0x33 on consecutive cycles.
  - Outputs appear cycles 1–3 in order.
  - `count_o` stays at 1.
  - No bubbles.
- Fill and stall, DEPTH=3, `AFULL_LVL=2`: push A, B, C with `out_ready_i=0`.
  - `afull_o` rises after B.
  - `in_ready_o=0` after C.
  - A fourth push of D is ignored.
  - Release `out_ready_i`: output is A, B, C, then empty.
- Wrap, DEPTH=3: run 10 push/pop pairs with `out_ready_i` toggling every cycle. Data order is preserved across pointer wrap and `count_o` never exceeds 3.
- Flush while full with a simultaneous push, DEPTH=2:
  - Next cycle: `count_o=0`, `out_valid_o=0`, `out_data_o=0`.
  - The pushed value never appears.
- DEPTH=1 throughput: continuous valid/ready gives one transfer every 2 cycles. Asserting `rst_n` low mid-stream clears all outputs immediately.
